// File: rtl/fpu_float_normalize_round_pkg.sv
// Shared FPU types and constants: round modes, special kinds, exception flags and the
// IEEE-754 rounding-increment decision used by every datapath's final stage.
package fpu_float_normalize_round_pkg;

  typedef enum logic [1:0] {
    FPU_ROUND_MODE_EVEN = 2'd0,
    FPU_ROUND_MODE_DOWN = 2'd1,
    FPU_ROUND_MODE_UP   = 2'd2,
    FPU_ROUND_MODE_ZERO = 2'd3
  } fpu_round_mode_e;

  typedef enum logic [1:0] {
    FPU_SPECIAL_NONE = 2'd0,
    FPU_SPECIAL_NAN  = 2'd1,
    FPU_SPECIAL_INF  = 2'd2
  } fpu_special_e;

  typedef struct packed {
    logic inexact;
    logic overflow;
    logic underflow;
  } fpu_flags_t;

  localparam logic [31:0] FPU_FLOAT_NAN        = 32'hFFFF_FFFF;
  localparam logic [31:0] FPU_FLOAT_POS_INF    = 32'h7F80_0000;
  localparam logic [31:0] FPU_FLOAT_NEG_INF    = 32'hFF80_0000;
  localparam logic [31:0] FPU_FLOAT_MAX_FINITE = 32'h7F7F_FFFF;

  function automatic logic fpu_round_increment(input fpu_round_mode_e mode, input logic sign,
                                               input logic lsb, input logic [1:0] guard,
                                               input logic sticky);
    logic rb;
    logic rest;
    logic inc;
    rb   = guard[1];
    rest = guard[0] | sticky;
    inc  = 1'b0;
    unique case (mode)
      FPU_ROUND_MODE_EVEN: inc = rb & (rest | lsb);
      FPU_ROUND_MODE_UP:   inc = ~sign & (rb | rest);
      FPU_ROUND_MODE_DOWN: inc = sign & (rb | rest);
      FPU_ROUND_MODE_ZERO: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fpu_leading_zero_count.sv
// Combinational leading-zero counter over a 26-bit vector; all-zero input yields 26.
module fpu_leading_zero_count (
  input  logic [25:0] data_i,
  output logic [4:0]  count_o
);

  always_comb begin
    count_o = 5'd26;
    // Ascending scan so the most significant set bit wins.
    for (int i = 0; i < 26; i++) begin
      if (data_i[i]) count_o = 5'(25 - i);
    end
  end

endmodule

// File: rtl/fpu_float_normalize_round.sv
// Two-stage normalize/round/pack back end for binary32 results with valid/ready on both sides.
// Stage 1 normalizes so the hidden bit lands at bit 23; stage 2 rounds, range-checks and packs.
module fpu_float_normalize_round
  import fpu_float_normalize_round_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_WIDTH-1:0] in_exponent,
  input  logic [24:0]          in_mantissa,
  input  logic [1:0]           in_guard,
  input  logic                 in_sticky,
  input  logic [1:0]           in_round_mode,
  input  logic [1:0]           in_special,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_inexact,
  output logic                 out_overflow,
  output logic                 out_underflow
);

  // Two guard bits of headroom so +1 and -26 adjustments never wrap.
  localparam int unsigned EW = EXP_WIDTH + 2;

  typedef struct packed {
    logic            sign;
    logic [EW-1:0]   exp;
    logic [22:0]     frac;
    logic [1:0]      guard;
    logic            sticky;
    fpu_round_mode_e mode;
    fpu_special_e    special;
    logic            zero;
  } norm_t;

  logic       s1_valid_q, s1_valid_d;
  norm_t      s1_q, s1_d, norm;
  logic       out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  fpu_flags_t out_flags_q, out_flags_d;

  logic in_fire, s2_ready, s1_advance;

  assign s2_ready   = ~out_valid_q | out_ready;
  assign s1_advance = s1_valid_q & s2_ready;
  assign in_ready   = ~s1_valid_q | s1_advance;
  assign in_fire    = in_valid & in_ready;

  // Stage 1: normalize
  logic [4:0]    lz;
  logic [EW-1:0] exp_ext;
  logic [25:0]   shifted;
  logic [23:0]   mant_n;
  logic          unused_hidden;

  fpu_leading_zero_count u_lzc (
    .data_i  ({in_mantissa[23:0], in_guard}),
    .count_o (lz)
  );

  assign exp_ext       = {{2{in_exponent[EXP_WIDTH-1]}}, in_exponent};
  assign shifted       = {in_mantissa[23:0], in_guard} << lz;
  assign unused_hidden = mant_n[23];

  always_comb begin
    norm         = '0;
    norm.sign    = in_sign;
    norm.mode    = fpu_round_mode_e'(in_round_mode);
    norm.special = fpu_special_e'(in_special);
    norm.zero    = ~|{in_mantissa, in_guard, in_sticky};
    norm.sticky  = in_sticky;
    norm.guard   = in_guard;
    norm.exp     = exp_ext;
    mant_n       = in_mantissa[23:0];
    if (in_mantissa[24]) begin
      mant_n      = in_mantissa[24:1];
      norm.guard  = {in_mantissa[0], in_guard[1]};
      norm.sticky = in_sticky | in_guard[0];
      norm.exp    = exp_ext + EW'(1);
    end else if (!in_mantissa[23]) begin
      mant_n     = shifted[25:2];
      norm.guard = shifted[1:0];
      norm.exp   = exp_ext - EW'(lz);
    end
    norm.frac = mant_n[22:0];
  end

  always_comb begin
    s1_d       = in_fire ? norm : s1_q;
    s1_valid_d = s1_valid_q;
    if (in_fire)         s1_valid_d = 1'b1;
    else if (s1_advance) s1_valid_d = 1'b0;
  end

  // Stage 2: round, range check, pack. Adding inc to {exp, frac} lets a frac carry bump exp.
  logic          inc, inexact;
  logic [EW+22:0] rnd;
  logic [EW-1:0] exp_r;
  logic [31:0]   inf_word, max_word;

  assign inc      = fpu_round_increment(s1_q.mode, s1_q.sign, s1_q.frac[0], s1_q.guard,
                                        s1_q.sticky);
  assign rnd      = {s1_q.exp, s1_q.frac} + {{(EW + 22){1'b0}}, inc};
  assign exp_r    = rnd[EW+22:23];
  assign inexact  = |{s1_q.guard, s1_q.sticky};
  assign inf_word = s1_q.sign ? FPU_FLOAT_NEG_INF : FPU_FLOAT_POS_INF;
  assign max_word = {s1_q.sign, FPU_FLOAT_MAX_FINITE[30:0]};

  always_comb begin
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_valid_d  = out_valid_q;
    if (s2_ready) out_valid_d = s1_valid_q;
    if (s1_advance) begin
      out_flags_d = '0;
      if (s1_q.special == FPU_SPECIAL_NAN) begin
        out_result_d = FPU_FLOAT_NAN;
      end else if (s1_q.special == FPU_SPECIAL_INF) begin
        out_result_d = inf_word;
      end else if (s1_q.zero) begin
        out_result_d = {s1_q.sign, 31'd0};
      end else if ($signed(exp_r) >= $signed(EW'(255))) begin
        out_flags_d.overflow = 1'b1;
        out_flags_d.inexact  = 1'b1;
        unique case (s1_q.mode)
          FPU_ROUND_MODE_EVEN: out_result_d = inf_word;
          FPU_ROUND_MODE_ZERO: out_result_d = max_word;
          FPU_ROUND_MODE_UP:   out_result_d = s1_q.sign ? max_word : inf_word;
          FPU_ROUND_MODE_DOWN: out_result_d = s1_q.sign ? inf_word : max_word;
        endcase
      end else if ($signed(exp_r) <= $signed(EW'(0))) begin
        out_result_d          = {s1_q.sign, 31'd0};
        out_flags_d.underflow = 1'b1;
        out_flags_d.inexact   = 1'b1;
      end else begin
        out_result_d        = {s1_q.sign, exp_r[7:0], rnd[22:0]};
        out_flags_d.inexact = inexact;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_inexact   = out_flags_q.inexact;
  assign out_overflow  = out_flags_q.overflow;
  assign out_underflow = out_flags_q.underflow;

endmodule

// File: tb/tb_fpu_float_normalize_round.sv
// Self-checking bench: directed vectors, randomized traffic against an arithmetic reference
// model via an in-order scoreboard, backpressure and mid-stall reset.
module tb_fpu_float_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_sticky;
  logic [9:0]  in_exponent;
  logic [24:0] in_mantissa;
  logic [1:0]  in_guard, in_round_mode, in_special;
  logic        out_valid, out_ready, out_inexact, out_overflow, out_underflow;
  logic [31:0] out_result;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  logic [34:0] sb[$];

  always #5 clk = ~clk;

  fpu_float_normalize_round #(.EXP_WIDTH(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exponent   (in_exponent),
    .in_mantissa   (in_mantissa),
    .in_guard      (in_guard),
    .in_sticky     (in_sticky),
    .in_round_mode (in_round_mode),
    .in_special    (in_special),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_inexact   (out_inexact),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Reference: locate the MSB of the full {mant, guard} value, keep 24 significant bits,
  // round on the rest, then apply range rules. Returns {inexact, overflow, underflow, word}.
  function automatic logic [34:0] ref_model(input logic s, input int e_in, input logic [24:0] m,
                                            input logic [1:0] g, input logic st,
                                            input int mode, input int spec);
    longint mm, sig;
    int p, e;
    bit rb, rest, inc, lsb;
    logic [31:0] inf_w, max_w;
    if (spec == 1) return {3'b000, 32'hFFFF_FFFF};
    if (spec == 2) return {3'b000, s, 31'h7F80_0000};
    mm = longint'({m, g});
    if (mm == 0 && !st) return {3'b000, s, 31'd0};
    p = 0;
    for (int i = 0; i < 27; i++) if (((mm >> i) & 1) != 0) p = i;
    e = e_in + p - 25;
    if (p >= 24) begin
      sig  = mm >> (p - 23);
      rb   = ((mm >> (p - 24)) & 1) != 0;
      rest = st || ((mm & ((64'd1 << (p - 24)) - 1)) != 0);
    end else begin
      sig  = mm << (23 - p);
      rb   = 1'b0;
      rest = st;
    end
    lsb = (sig & 1) != 0;
    case (mode)
      0:       inc = rb && (rest || lsb);
      1:       inc = s && (rb || rest);
      2:       inc = !s && (rb || rest);
      default: inc = 1'b0;
    endcase
    sig = sig + longint'(inc);
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      e   = e + 1;
    end
    inf_w = {s, 31'h7F80_0000};
    max_w = {s, 31'h7F7F_FFFF};
    if (e >= 255) begin
      case (mode)
        0:       return {3'b110, inf_w};
        3:       return {3'b110, max_w};
        2:       return {3'b110, s ? max_w : inf_w};
        default: return {3'b110, s ? inf_w : max_w};
      endcase
    end
    if (e <= 0) return {3'b101, s, 31'd0};
    return {rb || rest, 2'b00, s, 8'(e), 23'(sig)};
  endfunction

  // Scoreboard: model results enqueued on accept, compared in order on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 35'(sb.size()), 35'd1);
        end else begin
          check_eq("result", {out_inexact, out_overflow, out_underflow, out_result},
                   sb.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready)
        sb.push_back(ref_model(in_sign, int'($signed(in_exponent)), in_mantissa, in_guard,
                               in_sticky, int'(in_round_mode), int'(in_special)));
    end
  end

  task automatic gen_beat();
    int e, k;
    in_sign     = 1'($urandom);
    e           = int'($urandom_range(0, 300)) - 20;
    in_exponent = 10'(e);
    in_mantissa = 25'($urandom) >> $urandom_range(0, 25);
    in_guard    = 2'($urandom);
    in_sticky   = 1'($urandom);
    if ($urandom_range(0, 15) == 0) begin
      in_mantissa = '0;
      in_guard    = '0;
    end
    if (in_mantissa == 0 && in_guard == 0) in_sticky = 1'b0;
    in_round_mode = 2'($urandom);
    k             = int'($urandom_range(0, 9));
    in_special    = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd0;
    in_valid      = 1'b1;
  endtask

  task automatic drive_beat(input logic s, input int e, input logic [24:0] m,
                            input logic [1:0] g, input logic [1:0] rm, input logic [1:0] sp);
    bit ok;
    @(posedge clk);
    #1;
    in_sign = s; in_exponent = 10'(e); in_mantissa = m; in_guard = g; in_sticky = 1'b0;
    in_round_mode = rm; in_special = sp; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", 35'(in_ready), 35'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic s, input int e, input logic [24:0] m,
                          input logic [1:0] g, input logic [1:0] rm, input logic [1:0] sp,
                          input logic [31:0] want, input logic [2:0] wflags);
    int lat;
    drive_beat(s, e, m, g, rm, sp);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check_eq({tag, "_lat"}, 35'(lat), 35'd2);
    check_eq(tag, {out_inexact, out_overflow, out_underflow, out_result}, {wflags, want});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, out0;
    bit acc, have_hold;
    logic [34:0] hold;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exponent = '0; in_mantissa = '0; in_guard = '0; in_sticky = 1'b0;
    in_round_mode = '0; in_special = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 35'(out_valid), 35'd0);
    check_eq("rst_in_ready", 35'(in_ready), 35'd1);
    check_eq("rst_data", {out_inexact, out_overflow, out_underflow, out_result}, 35'd0);

    directed("one",        0, 127, 25'h0800000, 2'b00, 2'd0, 2'd0, 32'h3F80_0000, 3'b000);
    directed("carry",      0, 127, 25'h0FFFFFF, 2'b10, 2'd0, 2'd0, 32'h4000_0000, 3'b100);
    directed("tie_even",   0, 127, 25'h0800000, 2'b10, 2'd0, 2'd0, 32'h3F80_0000, 3'b100);
    directed("tie_up",     0, 127, 25'h0800000, 2'b10, 2'd2, 2'd0, 32'h3F80_0001, 3'b100);
    directed("ovf_even",   0, 254, 25'h1800000, 2'b00, 2'd0, 2'd0, 32'h7F80_0000, 3'b110);
    directed("ovf_zero",   0, 254, 25'h1800000, 2'b00, 2'd3, 2'd0, 32'h7F7F_FFFF, 3'b110);
    directed("ovf_up_neg", 1, 254, 25'h1800000, 2'b00, 2'd2, 2'd0, 32'hFF7F_FFFF, 3'b110);
    directed("ovf_dn_neg", 1, 254, 25'h1800000, 2'b00, 2'd1, 2'd0, 32'hFF80_0000, 3'b110);
    directed("cancel",     0, 150, 25'h0000001, 2'b00, 2'd0, 2'd0, 32'h3F80_0000, 3'b000);
    directed("underflow",  1, 0,   25'h0800000, 2'b00, 2'd0, 2'd0, 32'h8000_0000, 3'b101);
    directed("zero_neg",   1, 40,  25'h0000000, 2'b00, 2'd2, 2'd0, 32'h8000_0000, 3'b000);
    directed("nan",        0, 127, 25'h0FFFFFF, 2'b11, 2'd0, 2'd1, 32'hFFFF_FFFF, 3'b000);
    directed("inf_neg",    1, 300, 25'h1FFFFFF, 2'b11, 2'd0, 2'd2, 32'hFF80_0000, 3'b000);

    // Randomized traffic with random backpressure; a beat is held until accepted.
    @(posedge clk);
    #1;
    gen_beat();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        if ($urandom_range(0, 3) != 0) gen_beat();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("rand_drain", 35'(sb.size()), 35'd0);

    // Stall the output: only two beats fit, and the presented result must hold.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    idx = 0;
    have_hold = 1'b0;
    hold = '0;
    gen_beat();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready;
      if (out_valid) begin
        if (have_hold)
          check_eq("bp_hold", {out_inexact, out_overflow, out_underflow, out_result}, hold);
        else begin
          hold = {out_inexact, out_overflow, out_underflow, out_result};
          have_hold = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        gen_beat();
      end
    end
    @(negedge clk);
    check_eq("bp_accepted", 35'(idx), 35'd2);
    check_eq("bp_in_ready", 35'(in_ready), 35'd0);
    out0 = n_out;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 4; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) gen_beat();
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("bp_all_accepted", 35'(idx), 35'd4);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("bp_out_count", 35'(n_out - out0), 35'd4);
    check_eq("bp_sb_empty", 35'(sb.size()), 35'd0);

    // Reset while stalled with both stages full discards everything in flight.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    gen_beat();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("stall_full", 35'(out_valid), 35'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_out_valid", 35'(out_valid), 35'd0);
    check_eq("rst_mid_in_ready", 35'(in_ready), 35'd1);
    out0 = n_out;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_no_out", 35'(n_out - out0), 35'd0);
    check_eq("rst_mid_out_valid2", 35'(out_valid), 35'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_float_normalize_round.md
Name: fpu_float_normalize_round

Overview:
- Final stage of single-precision FPU datapaths (add/mul/fma).
- Consumes an unnormalized mantissa with guard/sticky bits, a widened signed exponent, sign and round mode.
- Normalizes, rounds, and handles overflow/underflow, then packs an IEEE-754 binary32 word with exception flags.
- Two-stage pipeline with valid/ready flow control on both sides.

Parameters:
- EXP_WIDTH, 10: width of signed biased input exponent (two's complement; allows out-of-range values).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat
- in_sign  in  1  result sign
- in_exponent  in  EXP_WIDTH  signed biased exponent (bias 127)
- in_mantissa  in  25  {carry, hidden, frac[22:0]}
- in_guard  in  2  guard bits; [1] = round bit
- in_sticky  in  1  OR of all lower discarded bits
- in_round_mode  in  2  0 EVEN, 1 DOWN (toward -inf), 2 UP (toward +inf), 3 ZERO
- in_special  in  2  0 none, 1 NaN, 2 infinity
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  32  packed float
- out_inexact  out  1  flag
- out_overflow  out  1  flag
- out_underflow  out  1  flag

Behaviour:
- Reset: out_valid=0, all out_* data=0, both stage valids=0, in_ready=1 on the cycle after reset. Reset mid-operation discards in-flight beats.
- Handshake:
  - Transfer on valid&ready.
  - Stage N advances when stage N+1 is empty or advancing.
  - in_ready = ~s1_valid | s1_advance (combinational from out_ready; no bubble under full throughput).
  - Output data holds stable while out_valid & ~out_ready.
- Latency: exactly 2 cycles accept-to-out_valid with no stalls. Throughput is 1/cycle. Order is preserved.
- Stage 1, normalize:
  - If mantissa[24]=1: shift right 1, exp+1, guard={mant[0], guard[1]}, sticky|=guard[0].
  - Else if mantissa[23]=1: pass through unchanged.
  - Else: lz = leading zeros of {mant[23:0],guard}. Shift that 26-bit vector left by lz, exp-=lz. Sticky is unchanged.
  - All-zero mantissa, guard and sticky: mark exact zero.
- Stage 2, round:
  - Definitions: rb = guard[1], rest = guard[0]|sticky, lsb = mant[0].
  - Increment rule:
    - EVEN: inc = rb&(rest|lsb).
    - UP: inc = ~sign&(rb|rest).
    - DOWN: inc = sign&(rb|rest).
    - ZERO: inc = 0.
  - inexact = rb|rest.
  - Increment carrying out of bit 23 gives mantissa 1.0, exp+1.
- Stage 2, range check (after rounding):
  - Overflow, exp >= 255: overflow=1, inexact=1.
    - EVEN: ±inf.
    - ZERO: ±0x7F7FFFFF magnitude.
    - UP: +inf if positive, -max-finite if negative.
    - DOWN: -inf if negative, +max-finite if positive.
  - Underflow, exp <= 0 (no denormals): flush to signed zero, underflow=1, inexact=1.
  - Exact zero: signed zero, no flags.
- Specials bypass all rounding and clear all flags:
  - NaN gives 0xFFFFFFFF.
  - Infinity gives 0x7F800000 | sign<<31.
- Packing: {sign, exp[7:0], mant[22:0]}.

Decomposition:
- Shared fpu package gains:
  - round-mode enum: existing FPU_ROUND_MODE_* with the encoding above.
  - special-kind enum: FPU_SPECIAL_NONE/NAN/INF.
  - flags struct: inexact, overflow, underflow.
  - constant FPU_FLOAT_MAX_FINITE = 32'h7F7F_FFFF.
  - function fpu_round_increment(mode, sign, lsb, guard, sticky).
- Existing FPU_FLOAT_NAN and FPU_FLOAT_POS_INF/NEG_INF are reused.
- One sub-module: fpu_leading_zero_count (26-bit input, 5-bit count, combinational), reusable by the adder.

Test Plan:
- sign0 exp127 mant 0x0800000 guard00 EVEN, special none -> 0x3F800000 two cycles later, no flags.
- exp127 mant 0x0FFFFFF guard10 EVEN -> round carry renormalizes -> 0x40000000, inexact=1.
- Tie, round mode EVEN: exp127 mant 0x0800000 guard10 -> 0x3F800000 inexact (lsb 0, no increment).
- Tie, round mode UP: same input as above -> 0x3F800001.
- Overflow: exp254 mant 0x1800000 -> EVEN 0x7F800000 ovf+inexact; ZERO 0x7F7FFFFF; sign1 UP 0xFF7FFFFF.
- Cancellation/underflow:
  - exp150 mant 0x0000001 -> lz 23 -> 0x3F800000.
  - sign1 exp0 mant 0x0800000 -> 0x80000000 underflow.
- Backpressure: out_ready low 6 cycles while driving 4 beats -> exactly 2 accepted before in_ready=0, output stable. Release -> all 4 emerge in order, no duplicates. Assert rst mid-stall -> out_valid=0 next cycle.
